led_chase_sequencer: RTL and testbench
======================================

Name: led_chase_sequencer

Overview:
Sequencer that drives the board's 8-LED active-low one-hot display, owning the 3-bit LED index that the display decode consumes. It has a static mode, where the index follows the switches, and three animated modes (chase up, chase down, bounce) paced by an internal prescaler. It sits between the switch/mode inputs and the LED pins.

Parameters:
TICK_DIV, 4, enabled clk cycles per animation step; legal range 1..65535.
CNT_W, $clog2(TICK_DIV) with minimum 1, prescaler counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
enable  input  1  run/freeze control, sampled on clk.
mode  input  2  00 STATIC, 01 CHASE_UP, 10 CHASE_DOWN, 11 BOUNCE.
switch  input  3  LED index used in STATIC mode.
led  output  8  active-low one-hot: led = 8'hFF - (8'h01 << idx).
idx  output  3  current LED index (registered).
step  output  1  one-cycle pulse, high in the cycle the new idx is first visible after an animated advance.

Behaviour:
- Reset (rst=0, async): idx=0, led=8'hFE, step=0, cnt=0, dir=UP, mode_q=00. Effective immediately, including mid-sequence.
- All state updates happen on the rising edge of clk. led is combinational from idx, so no extra latency.
- enable=0: idx, cnt, dir and mode_q hold; step=0. mode and switch changes are ignored until enable=1.
- Mode change (enable=1 and mode != mode_q):
  - mode_q <= mode, cnt <= 0, dir <= UP, step <= 0.
  - No idx change on that edge, including in STATIC.
- STATIC, enabled, no mode change:
  - idx <= switch, giving 1-cycle latency.
  - cnt held at 0, step=0.
- Animated modes, enabled, no mode change:
  - Tick when cnt == TICK_DIV-1: cnt <= 0, idx advances on the same edge, and step is high the following cycle.
  - Otherwise cnt <= cnt+1.
  - TICK_DIV=1 gives a tick on every enabled edge.
- Advance rules:
  - CHASE_UP: idx+1, wraps 7->0.
  - CHASE_DOWN: idx-1, wraps 0->7.
  - BOUNCE with dir=UP: idx<7 -> idx+1; idx==7 -> idx=6 and dir=DOWN.
  - BOUNCE with dir=DOWN: idx>0 -> idx-1; idx==0 -> idx=1 and dir=UP.
  - The ends have no dwell, so the BOUNCE period is 14 steps.
- Animated modes start from the idx left by the previous mode; idx is not reset on mode change.
- Simultaneous events: mode change has priority over tick. enable=0 has priority over both.

Optional Feature:
Macro: LED_BLANK_EN.
- Defined: while enable=0, led is forced to 8'hFF (all off). idx and the rest of the state are held as usual. led shows idx again in the first cycle enable=1 is observed.
- Undefined: led always reflects idx, so the display freezes while enable=0.
- idx and step behaviour are identical in both builds.

Test Plan:
1. Reset check: rst=0 with random inputs -> led=8'hFE, idx=0, step=0, asynchronously (before the next clk edge).
2. STATIC: mode=00, enable=1, drive switch=5 -> after 1 edge idx=5, led=8'hDF. Then switch=0 -> led=8'hFE.
3. CHASE_UP, TICK_DIV=4, start idx=0: enter mode=01 (1 edge). Then idx=1 (led=8'hFD) after 4 more edges with step pulsing once, and wraps 7->0 after 32 edges total.
4. BOUNCE, TICK_DIV=1, from idx=0: sequence is 1..7,6..0,1 on consecutive edges, with step high every cycle after the first advance.
5. Freeze: in CHASE_DOWN at idx=3 mid-count, drop enable for 10 cycles -> idx=3, cnt unchanged, step=0. Re-enable -> the remaining count completes, then idx=2. With LED_BLANK_EN, led=8'hFF during the freeze.
6. Mode change on a tick edge: mode 01->10 at cnt==TICK_DIV-1 -> idx unchanged, cnt=0; the next step occurs TICK_DIV edges later and decrements.

Source files
------------

// File: rtl/led_chase_sequencer.sv
// led_chase_sequencer
//   Owns the 3-bit LED index for an 8-LED active-low one-hot display.
//   In STATIC mode the index follows the switches. In the three animated
//   modes (chase up, chase down, bounce) it steps once every TICK_DIV
//   enabled clocks.
//
//   Build option: define LED_BLANK_EN to force the LEDs off (8'hFF) while
//   enable is low. Without it the display simply freezes.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active low
//   enable  in   run (1) / freeze (0)
//   mode    in   00 STATIC, 01 CHASE_UP, 10 CHASE_DOWN, 11 BOUNCE
//   switch  in   LED index used in STATIC mode
//   led     out  active-low one-hot LED drive
//   idx     out  current LED index (registered)
//   step    out  one-cycle pulse marking a freshly advanced index
//
// Bounce direction state
//   state    | meaning
//   DIR_UP   | bounce is climbing toward 7
//   DIR_DOWN | bounce is falling toward 0
module led_chase_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [2:0] switch,
  output logic [7:0] led,
  output logic [2:0] idx,
  output logic       step
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_UP     = 2'b01,
    M_DOWN   = 2'b10,
    M_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             step_q, step_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= M_STATIC;
      dir_q  <= DIR_UP;
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    step_d = 1'b0;
    if (enable) begin
      if (mode != mode_q) begin
        // Mode change restarts pacing but keeps the index where it was.
        mode_d = mode_e'(mode);
        cnt_d  = '0;
        dir_d  = DIR_UP;
      end else if (mode_q == M_STATIC) begin
        idx_d = switch;
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          M_UP:   idx_d = idx_q + 3'd1;
          M_DOWN: idx_d = idx_q - 3'd1;
          M_BOUNCE: begin
            // Turn around at the ends without dwelling there.
            if (dir_q == DIR_UP) begin
              if (idx_q == 3'd7) begin
                idx_d = 3'd6;
                dir_d = DIR_DOWN;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              if (idx_q == 3'd0) begin
                idx_d = 3'd1;
                dir_d = DIR_UP;
              end else begin
                idx_d = idx_q - 3'd1;
              end
            end
          end
          default: idx_d = idx_q;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign idx  = idx_q;
  assign step = step_q;

`ifdef LED_BLANK_EN
  assign led = enable ? ~(8'h01 << idx_q) : 8'hFF;
`else
  assign led = ~(8'h01 << idx_q);
`endif

endmodule

// File: tb/tb_led_chase_sequencer.sv
module tb_led_chase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] switch = 3'd0;

  logic [7:0] led4, led1;
  logic [2:0] idx4, idx1;
  logic       step4, step1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_chase_sequencer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .switch(switch),
    .led(led4), .idx(idx4), .step(step4)
  );

  led_chase_sequencer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .switch(switch),
    .led(led1), .idx(idx1), .step(step1)
  );

  // Reference model, one slot per DUT: [0] TICK_DIV=4, [1] TICK_DIV=1.
  // Bounce is modelled as a position on a 14-step loop: phase p maps to
  // index p for p<=7 and 14-p otherwise.
  int td [2] = '{4, 1};
  int m_idx [2];
  int m_cnt [2];
  int m_mode [2];
  int m_ph [2];
  int m_step [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_mode[k] = 0; m_ph[k] = 0; m_step[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_step[k] = 0;
      if (enable) begin
        if (int'(mode) != m_mode[k]) begin
          m_mode[k] = int'(mode);
          m_cnt[k]  = 0;
          m_ph[k]   = m_idx[k];
        end else if (m_mode[k] == 0) begin
          m_idx[k] = int'(switch);
          m_cnt[k] = 0;
        end else if (m_cnt[k] == td[k] - 1) begin
          m_cnt[k]  = 0;
          m_step[k] = 1;
          case (m_mode[k])
            1: m_idx[k] = (m_idx[k] + 1) % 8;
            2: m_idx[k] = (m_idx[k] + 7) % 8;
            default: begin
              m_ph[k]  = (m_ph[k] + 1) % 14;
              m_idx[k] = (m_ph[k] <= 7) ? m_ph[k] : 14 - m_ph[k];
            end
          endcase
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_led(int k);
`ifdef LED_BLANK_EN
    if (!enable) return 8'hFF;
`endif
    return 8'hFF - (8'h01 << m_idx[k]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/idx4"},  {5'd0, idx4},  8'(m_idx[0]));
    chk({tag, "/led4"},  led4,          exp_led(0));
    chk({tag, "/step4"}, {7'd0, step4}, 8'(m_step[0]));
    chk({tag, "/idx1"},  {5'd0, idx1},  8'(m_idx[1]));
    chk({tag, "/led1"},  led1,          exp_led(1));
    chk({tag, "/step1"}, {7'd0, step1}, 8'(m_step[1]));
  endtask

  // One rising edge: update the model, then compare at the falling edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  int bexp [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int steps_seen;

  initial begin
    // 1. Asynchronous reset with random mode/switch.
    model_reset();
    enable = 1'b1;
    mode   = 2'($urandom);
    switch = 3'($urandom);
    #1;
    check_all("reset");
    chk("reset_led4", led4, 8'hFE);
    @(negedge clk);
    rst = 1'b1;
    mode = 2'b00;

    // 2. STATIC follows the switches with one cycle of latency.
    switch = 3'd5;
    cyc("static5");
    chk("static5_idx", {5'd0, idx4}, 8'd5);
    chk("static5_led", led4, 8'hDF);
    switch = 3'd0;
    cyc("static0");
    chk("static0_led", led4, 8'hFE);

    // 3. CHASE_UP from idx 0: first advance four edges after entry.
    mode = 2'b01;
    cyc("up_entry");
    chk("up_entry_idx", {5'd0, idx4}, 8'd0);
    steps_seen = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc("chase_up");
      if (step4) steps_seen++;
      if (i == 4) begin
        chk("up_first_idx", {5'd0, idx4}, 8'd1);
        chk("up_first_led", led4, 8'hFD);
        chk("up_first_step", {7'd0, step4}, 8'd1);
      end
    end
    chk("up_wrap_idx", {5'd0, idx4}, 8'd0);
    chk("up_step_count", 8'(steps_seen), 8'd8);

    // 4. BOUNCE on the TICK_DIV=1 instance from idx 0.
    mode = 2'b00; switch = 3'd0;
    cyc("to_static");
    cyc("static_zero");
    mode = 2'b11;
    cyc("bounce_entry");
    chk("bounce_entry_idx", {5'd0, idx1}, 8'd0);
    for (int i = 0; i < 15; i++) begin
      cyc("bounce");
      chk("bounce_seq", {5'd0, idx1}, 8'(bexp[i]));
      chk("bounce_step", {7'd0, step1}, 8'd1);
    end

    // 5. Freeze in CHASE_DOWN at idx 3, two counts in.
    mode = 2'b00; switch = 3'd3;
    cyc("to_static3");
    cyc("static3");
    mode = 2'b10;
    cyc("down_entry");
    cyc("down_cnt1");
    cyc("down_cnt2");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode = 2'($urandom); switch = 3'($urandom);
      cyc("freeze");
      chk("freeze_idx", {5'd0, idx4}, 8'd3);
      chk("freeze_step", {7'd0, step4}, 8'd0);
`ifdef LED_BLANK_EN
      chk("freeze_led", led4, 8'hFF);
`else
      chk("freeze_led", led4, 8'hF7);
`endif
    end
    mode = 2'b10;
    enable = 1'b1;
    #1;
    chk("unfreeze_led", led4, 8'hF7);
    cyc("resume_cnt3");
    chk("resume_hold", {5'd0, idx4}, 8'd3);
    cyc("resume_tick");
    chk("resume_idx", {5'd0, idx4}, 8'd2);
    chk("resume_step", {7'd0, step4}, 8'd1);

    // 6. Mode change landing on a tick edge.
    mode = 2'b00; switch = 3'd4;
    cyc("to_static4");
    cyc("static4");
    mode = 2'b01;
    cyc("up2_entry");
    cyc("up2_c1");
    cyc("up2_c2");
    cyc("up2_c3");
    mode = 2'b10;
    cyc("chg_on_tick");
    chk("chg_idx", {5'd0, idx4}, 8'd4);
    chk("chg_step", {7'd0, step4}, 8'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc("after_chg");
      chk("after_chg_hold", {5'd0, idx4}, 8'd4);
    end
    cyc("after_chg_tick");
    chk("after_chg_idx", {5'd0, idx4}, 8'd3);

    // 7. Randomized run with a reset dropped in mid-sequence.
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      switch = 3'($urandom);
      if (i == 200) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        #1;
        rst = 1'b1;
      end
      cyc("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
